// File: rtl/cs_merge_pkg.sv
// ---------------------------------------------------------------------------
// cs_merge_pkg
// Shared definitions for the carry-save merge stage: FSM state encoding and
// the default geometry / correction constant used by cs_merge_stage and
// cs_chunk_add.
// ---------------------------------------------------------------------------
package cs_merge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_W          = 6;
    localparam int DEF_CHUNK      = 2;
    // Unsigned arrays need no correction; the 3x3 signed multiplier
    // instance overrides this with 6'h28.
    localparam int DEF_CORR_CONST = 0;

endpackage

// File: rtl/cs_chunk_add.sv
// ---------------------------------------------------------------------------
// cs_chunk_add
// Purely combinational CHUNK-bit ripple-carry adder used to resolve one
// chunk of the carry-save pair per cycle.
//
// Ports:
//   a, b  : CHUNK-bit operands
//   cin   : carry in from the previous chunk
//   sum   : CHUNK-bit sum
//   cout  : carry out of the chunk MSB
// ---------------------------------------------------------------------------
module cs_chunk_add
    import cs_merge_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    always_comb begin
        logic carry;
        // NOTE: every output gets a default before the loop so no path
        // through this block can leave a value held, which would infer a latch.
        sum   = '0;
        carry = cin;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/cs_merge_stage.sv
// ---------------------------------------------------------------------------
// cs_merge_stage
// Resolves a carry-save (sum, carry) pair from a multiplier array into a
// two's-complement product. On acceptance the pair and CORR_CONST are folded
// by one 3:2 row into registered S/C; the S+C addition is then done CHUNK
// bits per cycle over W/CHUNK cycles, and the result is held until consumed.
//
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   in_valid  : upstream pair valid
//   in_ready  : stage accepts a pair this cycle (IDLE only)
//   in_sum    : W-bit sum vector
//   in_carry  : W-bit carry vector, already weight-aligned
//   out_valid : out_prod holds a result
//   out_ready : downstream consumes the result
//   out_prod  : (in_sum + in_carry + CORR_CONST) mod 2^W
//   busy      : high while resolving chunks
//   out_cout  : carry out of the final chunk (only with CS_MERGE_COUT_EN)
//
// Build option: define CS_MERGE_COUT_EN to add the out_cout port.
// ---------------------------------------------------------------------------
module cs_merge_stage
    import cs_merge_pkg::*;
#(
    parameter int           W          = DEF_W,
    parameter int           CHUNK      = DEF_CHUNK,
    parameter logic [W-1:0] CORR_CONST = W'(DEF_CORR_CONST)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_sum,
    input  logic [W-1:0] in_carry,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_prod,
    output logic         busy
`ifdef CS_MERGE_COUT_EN
    ,
    output logic         out_cout
`endif
);

    localparam int            NCHUNK = W / CHUNK;
    localparam int            KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

    state_t             state;
    logic [W-1:0]       s_q;
    logic [W-1:0]       c_q;
    logic [W-1:0]       prod_q;
    logic [KW-1:0]      k_q;
    logic               carry_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;

    // 3:2 compression of the incoming pair with the correction constant.
    // The majority term moves up one weight; its MSB carry has weight 2^W
    // and is dropped because the result is mod 2^W.
    logic [W-1:0]       csa_s;
    logic [W-1:0]       csa_maj;
    logic [W-1:0]       csa_c;

    assign csa_s   = in_sum ^ in_carry ^ CORR_CONST;
    assign csa_maj = (in_sum & in_carry) | (in_sum & CORR_CONST) | (in_carry & CORR_CONST);
    assign csa_c   = csa_maj << 1;

    logic [CHUNK-1:0]   a_chunk;
    logic [CHUNK-1:0]   b_chunk;
    logic [CHUNK-1:0]   add_sum;
    logic               add_cout;

    assign a_chunk = s_q[k_q*CHUNK +: CHUNK];
    assign b_chunk = c_q[k_q*CHUNK +: CHUNK];

    cs_chunk_add #(
        .CHUNK (CHUNK)
    ) u_chunk_add (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values; reset is checked first inside the clocked
    // block, making it synchronous.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            s_q         <= '0;
            c_q         <= '0;
            prod_q      <= '0;
            k_q         <= '0;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        s_q        <= csa_s;
                        c_q        <= csa_c;
                        k_q        <= '0;
                        carry_q    <= 1'b0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    prod_q[k_q*CHUNK +: CHUNK] <= add_sum;
                    carry_q                    <= add_cout;
                    k_q                        <= k_q + 1'b1;
                    if (k_q == K_LAST) begin
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    // in_ready rises only once IDLE is reached, so nothing is
                    // accepted in the handshake cycle itself.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_prod  = prod_q;
    assign busy      = busy_q;

`ifdef CS_MERGE_COUT_EN
    // After the last chunk the carry register holds the final carry out and
    // stays put through DONE.
    assign out_cout = carry_q;
`endif

endmodule

// File: tb/tb_cs_merge_stage.sv
// ---------------------------------------------------------------------------
// tb_cs_merge_stage
// Two instances share all inputs and run in lockstep: dut0 with the default
// correction (0), dut1 with the signed-array correction 6'h28. Expected
// products come from a vector table and are queued when a pair is accepted;
// a negedge monitor pops and compares on every output handshake.
// ---------------------------------------------------------------------------
module tb_cs_merge_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic [5:0] in_sum;
    logic [5:0] in_carry;
    logic       in_ready0, in_ready1;
    logic       out_valid0, out_valid1;
    logic       busy0, busy1;
    logic [5:0] prod0, prod1;
`ifdef CS_MERGE_COUT_EN
    logic       cout0, cout1;
`endif

    always #5 clk = ~clk;

    cs_merge_stage dut0 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready0),
        .in_sum    (in_sum),
        .in_carry  (in_carry),
        .out_valid (out_valid0),
        .out_ready (out_ready),
        .out_prod  (prod0),
        .busy      (busy0)
`ifdef CS_MERGE_COUT_EN
        ,
        .out_cout  (cout0)
`endif
    );

    cs_merge_stage #(
        .CORR_CONST (6'h28)
    ) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .in_sum    (in_sum),
        .in_carry  (in_carry),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .out_prod  (prod1),
        .busy      (busy1)
`ifdef CS_MERGE_COUT_EN
        ,
        .out_cout  (cout1)
`endif
    );

    typedef struct {
        logic [5:0] s;
        logic [5:0] c;
        logic [5:0] p0;
        logic [5:0] p1;
    } vec_t;

    typedef struct {
        logic [5:0] p0;
        logic [5:0] p1;
        logic       c0;
        logic       c1;
    } exp_t;

    int   checks = 0;
    int   fails  = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Carry out of the final chunk: top bit of S + C after the 3:2 row.
    function automatic logic model_cout(input logic [5:0] a, input logic [5:0] b, input logic [5:0] k);
        logic [5:0] s;
        logic [5:0] c;
        logic [6:0] t;
        s = a ^ b ^ k;
        c = ((a & b) | (a & k) | (b & k)) << 1;
        t = {1'b0, s} + {1'b0, c};
        return t[6];
    endfunction

    task automatic push_exp(input logic [5:0] s, input logic [5:0] c,
                            input logic [5:0] p0, input logic [5:0] p1);
        exp_t e;
        e.p0 = p0;
        e.p1 = p1;
        e.c0 = model_cout(s, c, 6'h00);
        e.c1 = model_cout(s, c, 6'h28);
        exp_q.push_back(e);
    endtask

    // Called and returns at posedge+1. Leaves in_valid high when hold = 1.
    task automatic accept(input logic [5:0] s, input logic [5:0] c,
                          input logic [5:0] p0, input logic [5:0] p1, input bit hold);
        int n;
        in_valid = 1'b1;
        in_sum   = s;
        in_carry = c;
        n = 0;
        while (!in_ready0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) check("accept_timeout", in_ready0, 1);
        else push_exp(s, c, p0, p1);
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_result();
        int n;
        out_ready = 1'b1;
        n = 0;
        while (!out_valid0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) check("result_timeout", out_valid0, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid0 && out_ready) begin
            if (exp_q.size() == 0) begin
                check("stale_result", out_valid0, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("prod0", prod0, mon_e.p0);
                check("prod1", prod1, mon_e.p1);
                check("lockstep_valid1", out_valid1, 1);
`ifdef CS_MERGE_COUT_EN
                check("cout0", cout0, mon_e.c0);
                check("cout1", cout1, mon_e.c1);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           sum    carry  +0     +28
        vecs[0] = '{6'h05, 6'h03, 6'h08, 6'h30};
        vecs[1] = '{6'h00, 6'h00, 6'h00, 6'h28};
        vecs[2] = '{6'h3F, 6'h01, 6'h00, 6'h28};
        vecs[3] = '{6'h2A, 6'h15, 6'h3F, 6'h27};
        vecs[4] = '{6'h3F, 6'h3F, 6'h3E, 6'h26};
        vecs[5] = '{6'h10, 6'h20, 6'h30, 6'h18};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_sum    = '0;
        in_carry  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_in_ready", in_ready0, 1);
        check("rst_out_valid", out_valid0, 0);
        check("rst_busy", busy0, 0);
        check("rst_prod", prod0, 0);
        check("rst_in_ready1", in_ready1, 1);
        check("rst_busy1", busy1, 0);

        // Latency: accepting edge is edge 1, result visible after edge 4
        accept(6'h05, 6'h03, 6'h08, 6'h30, 0);
        check("lat_e1_busy", busy0, 1);
        check("lat_e1_valid", out_valid0, 0);
        check("lat_e1_ready", in_ready0, 0);
        for (int e = 2; e <= 3; e++) begin
            @(posedge clk);
            #1;
            check("lat_busy", busy0, 1);
            check("lat_valid_low", out_valid0, 0);
        end
        @(posedge clk);
        #1;
        check("lat_e4_valid", out_valid0, 1);
        check("lat_e4_busy", busy0, 0);
        check("lat_e4_prod", prod0, 6'h08);
        wait_result();

        // Table vectors
        for (int i = 0; i < 6; i++) begin
            accept(vecs[i].s, vecs[i].c, vecs[i].p0, vecs[i].p1, 0);
            wait_result();
        end

        // Backpressure, input change during BUSY, back-to-back acceptance
        out_ready = 1'b0;
        accept(6'h2A, 6'h15, 6'h3F, 6'h27, 1);
        in_sum   = 6'h11;
        in_carry = 6'h22;
        for (int n = 0; n < 50 && !out_valid0; n++) begin
            @(posedge clk);
            #1;
        end
        check("bp_reach_done", out_valid0, 1);
        for (int n = 0; n < 5; n++) begin
            @(posedge clk);
            #1;
            check("bp_prod_stable", prod0, 6'h3F);
            check("bp_in_ready_low", in_ready0, 0);
            check("bp_valid_high", out_valid0, 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("b2b_idle_ready", in_ready0, 1);
        check("b2b_not_taken", busy0, 0);
        check("b2b_valid_low", out_valid0, 0);
        push_exp(6'h11, 6'h22, 6'h33, 6'h1B);
        @(posedge clk);
        #1;
        check("b2b_taken", busy0, 1);
        in_valid = 1'b0;
        wait_result();

        // Reset in the second BUSY cycle aborts the operation
        accept(6'h2A, 6'h15, 6'h3F, 6'h27, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_in_ready", in_ready0, 1);
        check("abort_busy", busy0, 0);
        check("abort_valid", out_valid0, 0);
        check("abort_prod", prod0, 0);
        out_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk);
            #1;
            check("abort_no_stale", out_valid0, 0);
        end
        out_ready = 1'b0;

        // Recovery after abort
        accept(6'h3F, 6'h3F, 6'h3E, 6'h26, 0);
        wait_result();
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/cs_merge_stage.md
CS_MERGE_STAGE -- requirements
Module: cs_merge_stage

Interface
REQ-001 SHALL have parameter W, default 6, meaning the width of the carry-save vectors and of the product.
REQ-002 SHALL have parameter CHUNK, default 2, meaning the bits resolved per cycle; W SHALL be an integer multiple of CHUNK.
REQ-003 SHALL have parameter CORR_CONST, W bits, default 0, meaning the constant added during the merge (signed-array correction; the 3x3 signed multiplier instance sets 6'h28).
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: upstream vector pair is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts a vector pair this cycle.
REQ-008 SHALL have port in_sum, input, W bits: sum vector from the carry-save array.
REQ-009 SHALL have port in_carry, input, W bits: carry vector from the array, already weight-aligned.
REQ-010 SHALL have port out_valid, output, 1 bit: out_prod holds a result.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream consumes the result.
REQ-012 SHALL have port out_prod, output, W bits: the resolved two's-complement result.
REQ-013 SHALL have port busy, output, 1 bit: high while in the BUSY state.

Function
REQ-014 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-015 SHALL drive in_ready = 1 only in IDLE.
REQ-016 SHALL, on in_valid & in_ready: compress in_sum, in_carry and CORR_CONST with one combinational 3:2 row into registered vectors S and C (C shifted left by 1, MSB carry dropped), clear the chunk counter and the carry register, and go to BUSY.
REQ-017 SHALL, in BUSY, add chunk k (bits k*CHUNK+CHUNK-1 .. k*CHUNK) of S and C plus the carry register each cycle, write the chunk into the result register, update the carry register and increment k.
REQ-018 SHALL go to DONE after exactly W/CHUNK BUSY cycles (3 with the defaults).
REQ-019 SHALL hold out_valid = 1 and out_prod stable in DONE until out_ready = 1, then return to IDLE at the next edge.
REQ-020 SHALL NOT accept new input in the DONE-to-IDLE cycle.
REQ-021 SHALL give out_prod = (in_sum + in_carry + CORR_CONST) mod 2^W.
REQ-022 SHALL ignore in_valid outside IDLE, and SHALL NOT accept input while in BUSY.
REQ-023 SHALL hold in_sum and in_carry sampled only at acceptance; upstream changes during BUSY have no effect.

Reset
REQ-024 SHALL, when rst = 1 at a clock edge, set state = IDLE, out_valid = 0, out_prod = 0, busy = 0, the counter, carry register, S and C to 0, and in_ready = 1 from the next cycle.
REQ-025 SHALL, when reset is asserted in BUSY or DONE, abort the in-flight operation and never present its result.

Configuration
REQ-026 SHALL, with CS_MERGE_COUT_EN defined, add an output port out_cout (1 bit) holding the carry out of the final chunk, valid with out_valid, and reset to 0.
REQ-027 SHALL, with CS_MERGE_COUT_EN undefined, omit the out_cout port and discard the final carry.

Structure
REQ-028 SHALL place the FSM state encoding (IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2) and the default W, CHUNK and CORR_CONST in the shared package cs_merge_pkg.
REQ-029 SHALL implement the per-cycle chunk adder as the sub-module cs_chunk_add (CHUNK-bit ripple adder with cin/cout, purely combinational).

Verification
REQ-030 SHALL cover: defaults, in_sum = 6'h05, in_carry = 6'h03 -> out_prod = 6'h08 with out_valid asserted on the 4th edge after acceptance.
REQ-031 SHALL cover: CORR_CONST = 6'h28, both inputs 0 -> out_prod = 6'h28.
REQ-032 SHALL cover wrap-around: in_sum = 6'h3F, in_carry = 6'h01 -> out_prod = 6'h00, with out_cout = 1 when CS_MERGE_COUT_EN is defined.
REQ-033 SHALL cover backpressure: out_ready held low 5 cycles in DONE -> out_prod stable, in_ready = 0 throughout, and a new in_valid is not accepted.
REQ-034 SHALL cover reset: rst pulsed in the 2nd BUSY cycle -> next cycle IDLE, out_valid = 0, out_prod = 0, and no stale result appears.
REQ-035 SHALL cover back-to-back operation: in_valid held high with two pairs -> the second pair is accepted only after the first result handshake, and both results are correct.
